// File: rtl/gemm_pkg.sv
// Shared constants, FSM encoding and packing helpers for the tiled int8 GEMM engine.
package gemm_pkg;

  localparam int TILE_M = 4;
  localparam int TILE_N = 4;
  localparam int TILE_K = 4;
  localparam int ELEM_W = 8;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } gemm_state_e;

  // LSB of element (r,c) in a row-major packed tile with `cols` columns of `w` bits.
  function automatic int elem_lsb(input int r, input int c, input int cols, input int w);
    return (r * cols + c) * w;
  endfunction

  function automatic int ceil_div(input int x, input int d);
    return (x + d - 1) / d;
  endfunction

endpackage

// File: rtl/gemm_accelerator_top_tile_mac_array.sv
// Combinational MxNxK signed dot-product array: one packed MxN tile of 32-bit lane sums.
module tile_mac_array
  import gemm_pkg::*;
#(
  parameter int InDataWidth = ELEM_W,
  parameter int M           = TILE_M,
  parameter int N           = TILE_N,
  parameter int K           = TILE_K
) (
  input  logic [InDataWidth*M*K-1:0] a_tile,
  input  logic [InDataWidth*K*N-1:0] b_tile,
  output logic [ACC_W*M*N-1:0]       p_tile
);

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic signed [ACC_W-1:0] prod [K];
        logic signed [ACC_W-1:0] sum;

        for (gk = 0; gk < K; gk++) begin : g_dep
          logic signed [InDataWidth-1:0]   a_e;
          logic signed [InDataWidth-1:0]   b_e;
          logic signed [2*InDataWidth-1:0] m_e;
          assign a_e = a_tile[elem_lsb(gi, gk, K, InDataWidth) +: InDataWidth];
          assign b_e = b_tile[elem_lsb(gk, gj, N, InDataWidth) +: InDataWidth];
          assign m_e = a_e * b_e;
          assign prod[gk] = ACC_W'(m_e);
        end

        always_comb begin
          sum = '0;
          for (int k = 0; k < K; k++) begin
            sum = sum + prod[k];
          end
        end

        assign p_tile[elem_lsb(gi, gj, N, ACC_W) +: ACC_W] = sum;
      end
    end
  endgenerate

endmodule

// File: rtl/gemm_accelerator_top.sv
// Tiled int8 GEMM controller: walks (mt,nt,kt) tiles, accumulates over K and writes packed C tiles.
module gemm_accelerator_top
  import gemm_pkg::*;
#(
  parameter int InDataWidth   = ELEM_W,
  parameter int M             = TILE_M,
  parameter int N             = TILE_N,
  parameter int K             = TILE_K,
  parameter int OutDataWidth  = ACC_W * M * N,
  parameter int AddrWidth     = 10,
  parameter int SizeAddrWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [SizeAddrWidth-1:0]      M_size_i,
  input  logic [SizeAddrWidth-1:0]      K_size_i,
  input  logic [SizeAddrWidth-1:0]      N_size_i,
  output logic [AddrWidth-1:0]          sram_a_addr_o,
  output logic [AddrWidth-1:0]          sram_b_addr_o,
  output logic [AddrWidth-1:0]          sram_c_addr_o,
  input  logic [InDataWidth*M*K-1:0]    sram_a_rdata_i,
  input  logic [InDataWidth*K*N-1:0]    sram_b_rdata_i,
  output logic [OutDataWidth-1:0]       sram_c_wdata_o,
  output logic                          sram_c_we_o,
  output logic                          done_o
);

  localparam int SW = SizeAddrWidth;
  localparam int WW = 2 * SizeAddrWidth;
  localparam logic [SW-1:0] ONE = SW'(1);

  gemm_state_e state_reg;
  logic [SW-1:0] mt_tiles_reg, kt_tiles_reg, nt_tiles_reg;
  logic [SW-1:0] mt_reg, nt_reg, kt_reg, mt_next, nt_next, kt_next;
  logic kt_wrap, nt_wrap, last_issue, size_zero, flush_cnt_reg;
  logic [AddrWidth-1:0] a_addr_reg, b_addr_reg, c_addr_reg, c_addr_d1_reg;
  logic v1_reg, first_d1_reg, last_d1_reg, we_reg, done_reg;
  logic [OutDataWidth-1:0] acc_reg, acc_next, prod_tile, wdata_reg;

  function automatic logic [AddrWidth-1:0] lin_addr(input logic [SW-1:0] row,
                                                    input logic [SW-1:0] stride,
                                                    input logic [SW-1:0] col);
    logic [WW-1:0] full;
    full = {{SW{1'b0}}, row} * {{SW{1'b0}}, stride} + {{SW{1'b0}}, col};
    return full[AddrWidth-1:0];
  endfunction

  assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign kt_wrap    = (kt_reg == kt_tiles_reg - ONE);
  assign nt_wrap    = (nt_reg == nt_tiles_reg - ONE);
  assign last_issue = kt_wrap && nt_wrap && (mt_reg == mt_tiles_reg - ONE);

  // kt is the fastest loop, then nt, then mt; everything returns to zero after the final triple.
  always_comb begin
    kt_next = kt_reg + ONE;
    nt_next = nt_reg;
    mt_next = mt_reg;
    if (kt_wrap) begin
      kt_next = '0;
      if (nt_wrap) begin
        nt_next = '0;
        mt_next = last_issue ? '0 : mt_reg + ONE;
      end else begin
        nt_next = nt_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      mt_tiles_reg  <= '0;
      kt_tiles_reg  <= '0;
      nt_tiles_reg  <= '0;
      mt_reg        <= '0;
      nt_reg        <= '0;
      kt_reg        <= '0;
      a_addr_reg    <= '0;
      b_addr_reg    <= '0;
      flush_cnt_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            if (size_zero) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              mt_tiles_reg <= SW'(ceil_div(int'(M_size_i), M));
              kt_tiles_reg <= SW'(ceil_div(int'(K_size_i), K));
              nt_tiles_reg <= SW'(ceil_div(int'(N_size_i), N));
              mt_reg       <= '0;
              nt_reg       <= '0;
              kt_reg       <= '0;
              a_addr_reg   <= '0;
              b_addr_reg   <= '0;
              state_reg    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          mt_reg     <= mt_next;
          nt_reg     <= nt_next;
          kt_reg     <= kt_next;
          a_addr_reg <= lin_addr(mt_next, kt_tiles_reg, kt_next);
          b_addr_reg <= lin_addr(kt_next, nt_tiles_reg, nt_next);
          if (last_issue) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            flush_cnt_reg <= 1'b1;
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  tile_mac_array #(
    .InDataWidth(InDataWidth),
    .M          (M),
    .N          (N),
    .K          (K)
  ) u_mac (
    .a_tile(sram_a_rdata_i),
    .b_tile(sram_b_rdata_i),
    .p_tile(prod_tile)
  );

  genvar gi;
  generate
    for (gi = 0; gi < M * N; gi++) begin : g_acc
      assign acc_next[gi*ACC_W +: ACC_W] = first_d1_reg ? prod_tile[gi*ACC_W +: ACC_W]
                                         : acc_reg[gi*ACC_W +: ACC_W] + prod_tile[gi*ACC_W +: ACC_W];
    end
  endgenerate

  // The *_d1 tags travel alongside the SRAM read so they line up with the returned tile data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_reg        <= 1'b0;
      first_d1_reg  <= 1'b0;
      last_d1_reg   <= 1'b0;
      c_addr_d1_reg <= '0;
      acc_reg       <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      c_addr_reg    <= '0;
    end else begin
      v1_reg        <= (state_reg == ST_RUN);
      first_d1_reg  <= (kt_reg == '0);
      last_d1_reg   <= kt_wrap;
      c_addr_d1_reg <= lin_addr(mt_reg, nt_tiles_reg, nt_reg);
      if (v1_reg) begin
        acc_reg <= acc_next;
      end
      we_reg <= v1_reg && last_d1_reg;
      if (v1_reg && last_d1_reg) begin
        wdata_reg  <= acc_next;
        c_addr_reg <= c_addr_d1_reg;
      end
    end
  end

  assign sram_a_addr_o  = a_addr_reg;
  assign sram_b_addr_o  = b_addr_reg;
  assign sram_c_addr_o  = c_addr_reg;
  assign sram_c_wdata_o = wdata_reg;
  assign sram_c_we_o    = we_reg;
  assign done_o         = done_reg;

endmodule

// File: tb/tb_gemm_accelerator_top.sv
// Randomised self-checking bench: SRAM models, matrix-level golden GEMM, timing and write-order checks.
module tb_gemm_accelerator_top;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int AW = 10;
  localparam int SW = 8;
  localparam int IW = 8;
  localparam int OW = 32 * M * N;
  localparam int MAXD = 32;

  logic clk = 1'b0;
  logic rst_i, start_i;
  logic [SW-1:0] m_size, k_size, n_size;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [IW*M*K-1:0] a_rdata;
  logic [IW*K*N-1:0] b_rdata;
  logic [OW-1:0] c_wdata;
  logic c_we, done;

  int errors = 0;
  int checks = 0;

  int ga [MAXD][MAXD];
  int gb [MAXD][MAXD];
  logic [IW*M*K-1:0] mem_a [1024];
  logic [IW*K*N-1:0] mem_b [1024];
  int wr_addr [$];
  logic [OW-1:0] wr_data [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  gemm_accelerator_top dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .M_size_i      (m_size),
    .K_size_i      (k_size),
    .N_size_i      (n_size),
    .sram_a_addr_o (a_addr),
    .sram_b_addr_o (b_addr),
    .sram_c_addr_o (c_addr),
    .sram_a_rdata_i(a_rdata),
    .sram_b_rdata_i(b_rdata),
    .sram_c_wdata_o(c_wdata),
    .sram_c_we_o   (c_we),
    .done_o        (done)
  );

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0 random, 1 identity x ramp, 2 all -128 x -128, 3 all 127 x -128
  task automatic fill(input int mode);
    for (int r = 0; r < MAXD; r++) begin
      for (int c = 0; c < MAXD; c++) begin
        case (mode)
          1:       begin ga[r][c] = (r == c) ? 1 : 0; gb[r][c] = r * 4 + c; end
          2:       begin ga[r][c] = -128; gb[r][c] = -128; end
          3:       begin ga[r][c] = 127;  gb[r][c] = -128; end
          default: begin
            ga[r][c] = int'($urandom_range(0, 255)) - 128;
            gb[r][c] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
  endtask

  task automatic load_mem(input int ms, input int ks, input int ns);
    int mtt, ktt, ntt, v;
    logic [IW*M*K-1:0] wa;
    logic [IW*K*N-1:0] wb;
    mtt = (ms + M - 1) / M;
    ktt = (ks + K - 1) / K;
    ntt = (ns + N - 1) / N;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int mt = 0; mt < mtt; mt++) begin
      for (int kt = 0; kt < ktt; kt++) begin
        wa = '0;
        for (int r = 0; r < M; r++) begin
          for (int c = 0; c < K; c++) begin
            v = (mt*M + r < ms && kt*K + c < ks) ? ga[mt*M + r][kt*K + c] : 0;
            wa[(r*K + c)*IW +: IW] = 8'(v);
          end
        end
        mem_a[mt*ktt + kt] = wa;
      end
    end
    for (int kt = 0; kt < ktt; kt++) begin
      for (int nt = 0; nt < ntt; nt++) begin
        wb = '0;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < N; c++) begin
            v = (kt*K + r < ks && nt*N + c < ns) ? gb[kt*K + r][nt*N + c] : 0;
            wb[(r*N + c)*IW +: IW] = 8'(v);
          end
        end
        mem_b[kt*ntt + nt] = wb;
      end
    end
  endtask

  // Plain matrix product of the valid region; lanes outside the matrix are zero.
  function automatic logic [OW-1:0] gold_tile(input int mt, input int nt, input int ms,
                                               input int ks, input int ns);
    logic [OW-1:0] w;
    int s, gr, gc;
    w = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        gr = mt*M + r;
        gc = nt*N + c;
        s = 0;
        if (gr < ms && gc < ns) begin
          for (int k = 0; k < ks; k++) s += ga[gr][k] * gb[k][gc];
        end
        w[(r*N + c)*32 +: 32] = 32'(s);
      end
    end
    return w;
  endfunction

  task automatic run_job(input int ms, input int ks, input int ns, input bit busy_start,
                         input string name);
    int mtt, ktt, ntt, total, exp_wr, exp_done, done_cyc, last_wr_cyc, cyc;
    bit zero;
    zero = (ms == 0) || (ks == 0) || (ns == 0);
    mtt = (ms + M - 1) / M;
    ktt = (ks + K - 1) / K;
    ntt = (ns + N - 1) / N;
    total  = zero ? 0 : mtt * ktt * ntt;
    exp_wr = zero ? 0 : mtt * ntt;
    exp_done = zero ? 1 : total + 3;
    if (!zero) load_mem(ms, ks, ns);
    wr_addr.delete();
    wr_data.delete();
    done_cyc = -1;
    last_wr_cyc = -1;
    @(negedge clk);
    m_size = SW'(ms);
    k_size = SW'(ks);
    n_size = SW'(ns);
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 600) begin
      if (c_we) begin
        wr_addr.push_back(int'(c_addr));
        wr_data.push_back(c_wdata);
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start_i = (busy_start && cyc == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk($sformatf("%s done_cycle", name), OW'(done_cyc), OW'(exp_done));
    @(negedge clk);
    chk($sformatf("%s done_pulse_width", name), OW'(done), OW'(0));
    chk($sformatf("%s write_count", name), OW'(wr_addr.size()), OW'(exp_wr));
    for (int i = 0; i < wr_addr.size() && i < exp_wr; i++) begin
      $display("%s: write %0d addr %0d", name, i, wr_addr[i]);
      chk($sformatf("%s w%0d addr", name, i), OW'(wr_addr[i]), OW'(i));
      chk($sformatf("%s w%0d data", name, i), wr_data[i],
          gold_tile(i / ntt, i % ntt, ms, ks, ns));
    end
    if (exp_wr > 0)
      chk($sformatf("%s last_write_cycle", name), OW'(last_wr_cyc), OW'(total + 2));
    $display("%s: job %0dx%0dx%0d done at cycle %0d", name, ms, ks, ns, done_cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] w;
    int bad;
    rst_i = 1'b1;
    start_i = 1'b0;
    m_size = '0;
    k_size = '0;
    n_size = '0;
    repeat (2) @(negedge clk);
    chk("reset a_addr", OW'(a_addr), OW'(0));
    chk("reset b_addr", OW'(b_addr), OW'(0));
    chk("reset c_addr", OW'(c_addr), OW'(0));
    chk("reset c_wdata", c_wdata, '0);
    chk("reset c_we", OW'(c_we), OW'(0));
    chk("reset done", OW'(done), OW'(0));
    rst_i = 1'b0;

    fill(1);
    run_job(4, 4, 4, 1'b0, "identity");
    w = wr_data.size() > 0 ? wr_data[0] : '0;
    chk("identity lane(1,2)", OW'(w[(1*4 + 2)*32 +: 32]), OW'(32'd6));

    fill(2);
    run_job(4, 4, 4, 1'b0, "neg_neg");
    w = wr_data.size() > 0 ? wr_data[0] : '0;
    chk("neg_neg lane0", OW'(w[31:0]), OW'(32'd65536));

    fill(3);
    run_job(4, 4, 4, 1'b0, "pos_neg");
    w = wr_data.size() > 0 ? wr_data[0] : '0;
    chk("pos_neg lane15", OW'(w[15*32 +: 32]), OW'(32'hFFFF0200));

    fill(0);
    run_job(8, 8, 8, 1'b1, "multi_busy_start");

    fill(0);
    run_job(5, 6, 7, 1'b0, "ragged");

    run_job(0, 4, 4, 1'b0, "zero_m");

    for (int t = 0; t < 3; t++) begin
      fill(0);
      run_job($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13), 1'b0,
              $sformatf("rand%0d", t));
    end

    // Abort a long job with an asynchronous reset between clock edges.
    fill(0);
    load_mem(16, 16, 16);
    @(negedge clk);
    m_size = 8'd16;
    k_size = 8'd16;
    n_size = 8'd16;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("midreset a_addr", OW'(a_addr), OW'(0));
    chk("midreset b_addr", OW'(b_addr), OW'(0));
    chk("midreset c_addr", OW'(c_addr), OW'(0));
    chk("midreset c_wdata", c_wdata, '0);
    chk("midreset c_we", OW'(c_we), OW'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (c_we || done) bad++;
    end
    chk("post_reset activity", OW'(bad), OW'(0));
    run_job(16, 16, 16, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
